// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// captures the fetched word into the IF/ID register and hands it to decode
// over a valid/ready handshake. Supports backpressure, redirect with flush,
// and a fetch-enable gate.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetch_count and
// perf_stall_count outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count
`endif
);

    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_out_pc;
    logic        w_advance;

    // IF/ID register can take a new word when empty or when decode drains it
    always_comb begin
        w_advance = !r_valid || out_ready;
    end

    // PC and IF/ID register update: redirect > fetch > bubble > stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_out_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (fetch_enable) begin
                r_instr  <= instruction;
                r_out_pc <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= r_pc + PC_STEP;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign instruction_address = r_pc;
    assign out_valid           = r_valid;
    assign out_instruction     = r_instr;
    assign out_pc              = r_out_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Count completed handshakes and cycles held by decode backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_valid && out_ready)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (r_valid && !out_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_count = r_fetch_cnt;
    assign perf_stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_address;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
`endif

    logic [31:0] mem [0:255];

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_oi;
    logic [31:0] m_op;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_enable       (fetch_enable),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instruction_address(instruction_address),
        .instruction        (instruction),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_instruction    (out_instruction),
        .out_pc             (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_count   (perf_fetch_count),
        .perf_stall_count   (perf_stall_count)
`endif
    );

    assign instruction = mem[instruction_address[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_oi    = 32'h0000_0013;
        m_op    = 32'h0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;
    endtask

    // Advance one clock: model takes the edge using the current inputs
    task automatic cycle();
        logic can_take;
        can_take = !m_valid || out_ready;
        if (m_valid && out_ready)  m_fc = m_fc + 1;
        if (m_valid && !out_ready) m_sc = m_sc + 1;
        if (redirect_valid) begin
            m_pc    = redirect_pc;
            m_valid = 1'b0;
        end else if (can_take && fetch_enable) begin
            m_oi    = mem[int'(m_pc % 32'd256)];
            m_op    = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end else if (can_take) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        fetch_enable   = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_instruction, out_pc, instruction_address} !==
            {1'b0, 32'h0000_0013, 32'h0, 32'h0})
            $display("FAIL reset_async: got v=%0b ins=%h pc=%h addr=%h, want v=0 ins=00000013 pc=0 addr=0",
                     out_valid, out_instruction, out_pc, instruction_address);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if ({out_valid, out_instruction, instruction_address} !== {1'b0, 32'h0000_0013, 32'h0})
            $display("FAIL reset_held: got v=%0b ins=%h addr=%h, want v=0 ins=00000013 addr=0",
                     out_valid, out_instruction, instruction_address);
        else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++;
        if ({perf_fetch_count, perf_stall_count} !== 64'h0)
            $display("FAIL reset_perf: got fetch=%0d stall=%0d, want 0 0", perf_fetch_count, perf_stall_count);
        else n_pass++;
`endif
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_streaming();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'h1111_1111;
        exp_i[1] = 32'h2222_2222;
        exp_i[2] = 32'h3333_3333;
        exp_i[3] = 32'h4444_4444;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_total++;
            if ({out_valid, out_pc, out_instruction, instruction_address} !==
                {1'b1, 32'(k), exp_i[k], 32'(k + 1)})
                $display("FAIL stream[%0d]: got v=%0b pc=%h ins=%h addr=%h, want v=1 pc=%h ins=%h addr=%h",
                         k, out_valid, out_pc, out_instruction, instruction_address,
                         32'(k), exp_i[k], 32'(k + 1));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] stall_base;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        cycle();
        n_total++;
        if ({out_valid, out_pc} !== {1'b1, 32'h1})
            $display("FAIL bp_setup: got v=%0b pc=%h, want v=1 pc=1", out_valid, out_pc);
        else n_pass++;
        stall_base = m_sc;
`ifdef FETCH_PERF_CNT_EN
        stall_base = perf_stall_count;
`endif
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_total++;
            if ({out_valid, out_pc, out_instruction, instruction_address} !==
                {1'b1, 32'h1, 32'h2222_2222, 32'h2})
                $display("FAIL bp_hold[%0d]: got v=%0b pc=%h ins=%h addr=%h, want v=1 pc=1 ins=22222222 addr=2",
                         k, out_valid, out_pc, out_instruction, instruction_address);
            else n_pass++;
        end
`ifdef FETCH_PERF_CNT_EN
        n_total++;
        if (perf_stall_count - stall_base !== 32'd3)
            $display("FAIL bp_stall_count: got delta=%0d, want 3", perf_stall_count - stall_base);
        else n_pass++;
`endif
        out_ready = 1'b1;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h2, 32'h3333_3333})
            $display("FAIL bp_release: got v=%0b pc=%h ins=%h, want v=1 pc=2 ins=33333333",
                     out_valid, out_pc, out_instruction);
        else n_pass++;
    endtask

    task automatic test_redirect_stalled();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        cycle();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        cycle();
        n_total++;
        if ({out_valid, out_pc, instruction_address} !== {1'b0, 32'h1, 32'h10})
            $display("FAIL redir_stall_bubble: got v=%0b pc=%h addr=%h, want v=0 pc=1 addr=10",
                     out_valid, out_pc, instruction_address);
        else n_pass++;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h10, mem[16]})
            $display("FAIL redir_stall_target: got v=%0b pc=%h ins=%h, want v=1 pc=10 ins=%h",
                     out_valid, out_pc, out_instruction, mem[16]);
        else n_pass++;
    endtask

    task automatic test_redirect_fetch_enable();
        fetch_enable   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        cycle();
        redirect_valid = 1'b0;
        n_total++;
        if ({out_valid, instruction_address} !== {1'b0, 32'h20})
            $display("FAIL redir_fe_load: got v=%0b addr=%h, want v=0 addr=20", out_valid, instruction_address);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_total++;
            if ({out_valid, instruction_address} !== {1'b0, 32'h20})
                $display("FAIL redir_fe_idle[%0d]: got v=%0b addr=%h, want v=0 addr=20",
                         k, out_valid, instruction_address);
            else n_pass++;
        end
        fetch_enable = 1'b1;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction, instruction_address} !== {1'b1, 32'h20, mem[32], 32'h21})
            $display("FAIL redir_fe_resume: got v=%0b pc=%h ins=%h addr=%h, want v=1 pc=20 ins=%h addr=21",
                     out_valid, out_pc, out_instruction, instruction_address, mem[32]);
        else n_pass++;
    endtask

    task automatic test_wrap_alias();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFF;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'hFF, mem[255]})
            $display("FAIL alias_ff: got v=%0b pc=%h ins=%h, want v=1 pc=ff ins=%h",
                     out_valid, out_pc, out_instruction, mem[255]);
        else n_pass++;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h100, mem[0]})
            $display("FAIL alias_100: got v=%0b pc=%h ins=%h, want v=1 pc=100 ins=%h",
                     out_valid, out_pc, out_instruction, mem[0]);
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction, instruction_address} !==
            {1'b1, 32'hFFFF_FFFF, mem[255], 32'h0})
            $display("FAIL pc_wrap: got v=%0b pc=%h ins=%h addr=%h, want v=1 pc=ffffffff ins=%h addr=0",
                     out_valid, out_pc, out_instruction, instruction_address, mem[255]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            fetch_enable   = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom();
            cycle();
            n_total++;
            if ({out_valid, out_instruction, out_pc, instruction_address} !== {m_valid, m_oi, m_op, m_pc})
                $display("FAIL random[%0d]: got v=%0b ins=%h pc=%h addr=%h, want v=%0b ins=%h pc=%h addr=%h",
                         k, out_valid, out_instruction, out_pc, instruction_address,
                         m_valid, m_oi, m_op, m_pc);
            else n_pass++;
        end
`ifdef FETCH_PERF_CNT_EN
        n_total++;
        if ({perf_fetch_count, perf_stall_count} !== {m_fc, m_sc})
            $display("FAIL random_perf: got fetch=%0d stall=%0d, want fetch=%0d stall=%0d",
                     perf_fetch_count, perf_stall_count, m_fc, m_sc);
        else n_pass++;
`endif
        fetch_enable   = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        cycle();
        n_total++;
        if ({out_valid, out_pc} !== {1'b1, 32'h6})
            $display("FAIL areset_setup: got v=%0b pc=%h, want v=1 pc=6", out_valid, out_pc);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_instruction, out_pc, instruction_address} !==
            {1'b0, 32'h0000_0013, 32'h0, 32'h0})
            $display("FAIL areset_immediate: got v=%0b ins=%h pc=%h addr=%h, want v=0 ins=00000013 pc=0 addr=0",
                     out_valid, out_instruction, out_pc, instruction_address);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        n_total++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h0, mem[0]})
            $display("FAIL areset_restart: got v=%0b pc=%h ins=%h, want v=1 pc=0 ins=%h",
                     out_valid, out_pc, out_instruction, mem[0]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_stalled();
        test_redirect_fetch_enable();
        test_wrap_alias();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
